// File: rtl/seq_multiplier_hs_if.sv
// rtl/seq_multiplier_hs_if.sv - operand/result handshake bundle for seq_multiplier_hs
//
// Purpose: groups the operand-side and result-side valid/ready handshakes
// of the sequential multiplier into one bundle.
// Signals:
//   in_valid, a, b, signed_mode : operand request (producer -> multiplier)
//   in_ready                    : multiplier can accept operands
//   out_valid, product          : result (multiplier -> consumer)
//   out_ready                   : consumer accepts the result
//   busy                        : multiplier is in CALC or DONE
// Modports: master = producer/consumer side, slave = multiplier side.
interface seq_multiplier_hs_if #(
  parameter int WIDTH = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 signed_mode;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   product;
  logic                 busy;

  modport master (
    output in_valid, a, b, signed_mode, out_ready,
    input  in_ready, out_valid, product, busy
  );

  modport slave (
    input  in_valid, a, b, signed_mode, out_ready,
    output in_ready, out_valid, product, busy
  );
endinterface

// File: rtl/seq_multiplier_hs.sv
// rtl/seq_multiplier_hs.sv - shift-add sequential multiplier with valid/ready handshakes
//
// Purpose: multiplies two WIDTH-bit operands (signed or unsigned) by
// retiring one multiplier bit per clock, then holds the 2*WIDTH-bit
// product until the consumer takes it.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous, active-high reset
//   bus  : seq_multiplier_hs_if.slave (operand handshake, result handshake, busy)
// Configuration:
//   SEQ_MULT_EARLY_EXIT_EN : when defined, CALC also ends as soon as the
//                            remaining multiplier bits are all zero
//                            (data-dependent latency, identical products).
module seq_multiplier_hs #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  seq_multiplier_hs_if.slave bus
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0]   md;
  logic [WIDTH-1:0]   mr;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] product_q;
  logic [CW-1:0]      cnt;
  logic               neg;

  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [2*WIDTH-1:0] addend;
  logic [2*WIDTH-1:0] acc_sum;
  logic [WIDTH-1:0]   mr_shift;
  logic               calc_last;

  // Magnitudes are WIDTH-bit unsigned, so -2^(WIDTH-1) maps to 2^(WIDTH-1)
  // without needing an extra bit.
  always_comb begin
    a_mag = bus.a;
    b_mag = bus.b;
    if (bus.signed_mode && bus.a[WIDTH-1]) a_mag = WIDTH'(0) - bus.a;
    if (bus.signed_mode && bus.b[WIDTH-1]) b_mag = WIDTH'(0) - bus.b;
  end

  // Datapath for the current CALC cycle; acc_sum includes this cycle's add
  // so the final product can be formed on the same edge that leaves CALC.
  always_comb begin
    addend   = '0;
    if (mr[0]) addend = {{WIDTH{1'b0}}, md} << cnt;
    acc_sum  = acc + addend;
    mr_shift = mr >> 1;
`ifdef SEQ_MULT_EARLY_EXIT_EN
    calc_last = (cnt == CNT_LAST) || (mr_shift == '0);
`else
    calc_last = (cnt == CNT_LAST);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next    = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b1;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        bus.busy     = 1'b0;
        if (bus.in_valid) state_next = CALC;
      end
      CALC: begin
        if (calc_last) state_next = DONE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      md        <= '0;
      mr        <= '0;
      acc       <= '0;
      cnt       <= '0;
      neg       <= 1'b0;
      product_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            md  <= a_mag;
            mr  <= b_mag;
            neg <= bus.signed_mode & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            acc <= '0;
            cnt <= '0;
          end
        end
        CALC: begin
          acc <= acc_sum;
          mr  <= mr_shift;
          cnt <= cnt + CW'(1);
          if (calc_last) product_q <= neg ? ((2*WIDTH)'(0) - acc_sum) : acc_sum;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.product = product_q;

endmodule

// File: tb/tb_seq_multiplier_hs.sv
// tb/tb_seq_multiplier_hs.sv - self-checking bench for seq_multiplier_hs
module tb_seq_multiplier_hs;
  localparam int W = 8;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  seq_multiplier_hs_if #(.WIDTH(W)) bus ();

  seq_multiplier_hs #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           sm;
    logic [2*W-1:0] exp_p;
    string          name;
  } vec_t;

  vec_t tbl[11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference product from plain integer arithmetic, truncated to 2*W bits.
  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic sm);
    longint sa, sb, p;
    logic [63:0] pv;
    sa = sm ? longint'($signed(a)) : longint'(a);
    sb = sm ? longint'($signed(b)) : longint'(b);
    p  = sa * sb;
    pv = p;
    return pv[2*W-1:0];
  endfunction

  // Number of CALC cycles the specification allows for this multiplier.
  function automatic int ref_calc_cycles(input logic [W-1:0] b, input logic sm);
    int mag, n;
    mag = sm ? int'($signed(b)) : int'(b);
    if (mag < 0) mag = -mag;
`ifdef SEQ_MULT_EARLY_EXIT_EN
    n = 1;
    for (int k = 0; k <= W; k++) if (((mag >> k) & 1) != 0) n = k + 1;
`else
    n = W;
`endif
    return n;
  endfunction

  // Apply one operation with out_ready high; edges are counted including the
  // accepting edge up to the edge after which out_valid is seen.
  task automatic run_vec(input logic [W-1:0] a, input logic [W-1:0] b, input logic sm,
                         input logic [2*W-1:0] exp_p, input string name);
    int edges;
    bit seen;
    check({name, "_in_ready"}, 64'(bus.in_ready), 64'd1);
    bus.a = a; bus.b = b; bus.signed_mode = sm;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    step();
    bus.in_valid = 1'b0;
    bus.a = ~a; bus.b = ~b; bus.signed_mode = ~sm;
    edges = 1;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (bus.out_valid) seen = 1'b1;
      else begin
        step();
        edges++;
      end
    end
    check({name, "_latency"}, 64'(edges), 64'(ref_calc_cycles(b, sm) + 1));
    check({name, "_product"}, 64'(bus.product), 64'(exp_p));
    step();
    check({name, "_back_idle"}, 64'(bus.in_ready), 64'd1);
  endtask

  logic [2*W-1:0] held;
  logic [2*W-1:0] sbq[$];
  int accepted, cyc;
  bit hs_in, hs_out, seen_v;

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.signed_mode = 1'b0;
    bus.out_ready = 1'b0;

    tbl[0]  = '{8'd13, 8'd11, 1'b0, 16'h008F, "u13x11"};
    tbl[1]  = '{8'hFD, 8'h05, 1'b1, 16'hFFF1, "s_m3x5"};
    tbl[2]  = '{8'h80, 8'h80, 1'b1, 16'h4000, "s_min_sq"};
    tbl[3]  = '{8'hFF, 8'hFF, 1'b0, 16'hFE01, "u_max_sq"};
    tbl[4]  = '{8'h80, 8'h7F, 1'b1, 16'hC080, "s_min_x_max"};
    tbl[5]  = '{8'hFF, 8'hFF, 1'b1, 16'h0001, "s_m1_sq"};
    tbl[6]  = '{8'h7F, 8'h81, 1'b1, 16'hC0FF, "s_127x_m127"};
    tbl[7]  = '{8'h00, 8'h55, 1'b0, 16'h0000, "u_zero_a"};
    tbl[8]  = '{8'h2A, 8'h00, 1'b0, 16'h0000, "b_zero"};
    tbl[9]  = '{8'h07, 8'h01, 1'b0, 16'h0007, "b_one"};
    tbl[10] = '{8'h03, 8'h80, 1'b0, 16'h0180, "u_b_msb"};

    repeat (3) step();
    rst = 1'b0;
    check("reset_in_ready", 64'(bus.in_ready), 64'd1);
    check("reset_out_valid", 64'(bus.out_valid), 64'd0);
    check("reset_busy", 64'(bus.busy), 64'd0);
    check("reset_product", 64'(bus.product), 64'd0);

    foreach (tbl[i]) run_vec(tbl[i].a, tbl[i].b, tbl[i].sm, tbl[i].exp_p, tbl[i].name);

    // Backpressure: result held while the consumer stalls; operand pulses ignored.
    bus.out_ready = 1'b0;
    bus.a = 8'h21; bus.b = 8'h13; bus.signed_mode = 1'b0;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    seen_v = 1'b0;
    for (int i = 0; i < 40 && !seen_v; i++) begin
      if (bus.out_valid) seen_v = 1'b1;
      else step();
    end
    check("bp_reach_done", 64'(seen_v), 64'd1);
    held = bus.product;
    check("bp_product", 64'(held), 64'h0273);
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = (i % 2 == 0);
      bus.a = 8'(i + 1); bus.b = 8'h44;
      step();
      check("bp_out_valid", 64'(bus.out_valid), 64'd1);
      check("bp_product_stable", 64'(bus.product), 64'(held));
      check("bp_in_ready", 64'(bus.in_ready), 64'd0);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    step();
    check("bp_release_valid", 64'(bus.out_valid), 64'd0);
    check("bp_release_ready", 64'(bus.in_ready), 64'd1);
    check("bp_product_kept", 64'(bus.product), 64'(held));
    run_vec(8'h09, 8'h0B, 1'b0, 16'h0063, "after_bp");

    // Reset in the middle of CALC aborts the operation.
    bus.a = 8'h55; bus.b = 8'h33; bus.signed_mode = 1'b0;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    check("mid_busy", 64'(bus.busy), 64'd1);
    repeat (2) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_in_ready", 64'(bus.in_ready), 64'd1);
    check("abort_out_valid", 64'(bus.out_valid), 64'd0);
    check("abort_product", 64'(bus.product), 64'd0);
    check("abort_busy", 64'(bus.busy), 64'd0);
    run_vec(8'd2, 8'd3, 1'b0, 16'd6, "after_abort");

    // Random streaming with random stalls on both sides, scoreboard in order.
    accepted = 0;
    cyc = 0;
    while ((accepted < 1000 || sbq.size() != 0) && cyc < 60000) begin
      bus.a = W'($urandom);
      bus.b = W'($urandom);
      bus.signed_mode = 1'($urandom_range(0, 1));
      bus.in_valid = (accepted < 1000) && ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 9) < 7);
      hs_in = bus.in_valid && bus.in_ready;
      hs_out = bus.out_valid && bus.out_ready;
      if (hs_in) begin
        sbq.push_back(ref_mul(bus.a, bus.b, bus.signed_mode));
        accepted++;
      end
      if (hs_out) begin
        if (sbq.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL rand_extra_result: got 0x%0h expected no result", bus.product);
        end else begin
          check("rand_product", 64'(bus.product), 64'(sbq.pop_front()));
        end
      end
      step();
      cyc++;
    end
    bus.in_valid = 1'b0;
    check("rand_no_timeout", 64'(cyc < 60000), 64'd1);
    check("rand_drained", 64'(sbq.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/seq_multiplier_hs.md
# seq_multiplier_hs

Parametrised shift-add sequential multiplier with integrated controller and datapath, signed/unsigned mode, and valid/ready handshakes on both operand and result sides. It is the successor to the fixed-width constant-time multiplier controller. It drops into streaming pipelines where the producer and consumer may each stall. One multiplier bit is retired per clock. An optional early-exit mode shortens latency for small multipliers.

## Interface
- `WIDTH`, 8: operand width in bits; must be ≥2.
- `clk`  input  1  clock; all state changes on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `in_valid`  input  1  operands and mode present.
- `in_ready`  output  1  block can accept operands.
- `a`  input  WIDTH  multiplicand.
- `b`  input  WIDTH  multiplier.
- `signed_mode`  input  1  1 = two's-complement operands, 0 = unsigned; sampled with the operands.
- `out_valid`  output  1  `product` holds a valid result.
- `out_ready`  input  1  consumer accepts the result.
- `product`  output  2*WIDTH  result register.
- `busy`  output  1  high in CALC or DONE.

## Operation
- State machine: IDLE, CALC, DONE. The state register is the only encoded state.
- IDLE:
  - `in_ready` = 1.
  - On `in_valid` & `in_ready`, latch md = |a| and mr = |b|. Magnitudes are taken only when `signed_mode` = 1 and the operand MSB = 1; otherwise the raw value is used.
  - Also latch neg = `signed_mode` & (a[MSB] ^ b[MSB]), acc = 0, cnt = 0, then go to CALC.
- Magnitude is an unsigned WIDTH-bit value. The magnitude of −2^(WIDTH−1) is 2^(WIDTH−1), with no overflow.
- CALC, each cycle:
  - If mr[0], then acc += md << cnt. acc is 2*WIDTH bits and the add is never truncated.
  - Then mr >>= 1 and cnt += 1.
  - Exit to DONE when cnt == WIDTH−1 in the current cycle, or when the early-exit condition holds (see Configuration).
- Transition CALC→DONE: `product` ← neg ? −acc_final : acc_final, where acc_final includes the current cycle's add. The result is taken modulo 2^(2*WIDTH).
- DONE:
  - `out_valid` = 1; `product` is held stable.
  - On `out_ready`, go to IDLE.
- `product` holds its value after the handshake until the next result overwrites it.
- `in_valid` is ignored outside IDLE. `out_ready` is ignored outside DONE.
- `a`, `b` and `signed_mode` may change freely after acceptance.

## Timing
- Reset:
  - Forces state to IDLE and clears acc, mr, md, cnt, neg and `product` to 0.
  - Outputs after reset: `out_valid` = 0, `busy` = 0, `in_ready` = 1.
  - Reset mid-CALC or mid-DONE aborts the operation. No result is emitted.
- Outputs are registered-state decodes: `in_ready` = (IDLE), `out_valid` = (DONE), `busy` = !(IDLE). There is no combinational input-to-output path.
- Accept at edge E0:
  - CALC occupies cycles E0..E0+N−1, where N = WIDTH without early exit.
  - `out_valid` rises after edge E0+N.
- Fixed latency: `out_valid` asserts WIDTH+1 edges after the accepting edge.
- Throughput with `out_ready` tied high: one result per WIDTH+2 cycles, since DONE and IDLE each take one cycle.
- Backpressure: DONE is held indefinitely with `product` stable.

## Configuration
- `SEQ_MULT_EARLY_EXIT_EN` defined:
  - CALC also exits when the shifted mr becomes 0.
  - N = max(1, position of the highest set bit of |b| + 1).
  - b = 0 gives N = 1. Latency is data-dependent.
- Undefined: N = WIDTH always (constant-time); early-exit logic is absent.
- Both builds produce identical `product` values.

## Test plan
- WIDTH=8, unsigned, a=13, b=11, `out_ready`=1 -> `product`=0x008F; `out_valid` 9 edges after accept (macro undefined).
- Signed, a=0xFD (−3), b=0x05 -> `product`=0xFFF1. Also a=0x80, b=0x80 -> 0x4000. Unsigned 0xFF×0xFF -> 0xFE01.
- `out_ready` held low 5 cycles in DONE -> `out_valid` stays 1, `product` stays constant, `in_ready` stays 0; `in_valid` pulses are ignored.
- `rst` asserted 3 cycles after accept -> next cycle IDLE, `in_ready`=1, `out_valid`=0, `product`=0; the following op a=2, b=3 gives 6.
- With `SEQ_MULT_EARLY_EXIT_EN`: b=0 -> `out_valid` 2 edges after accept, `product`=0. b=1 (a=7) -> 2 edges, 7. b=0x80 (unsigned) -> 9 edges.
- Back-to-back random 1000 ops, signed and unsigned mixed, random `in_valid`/`out_ready` -> all match the reference model; no result is dropped or duplicated.
